// File: rtl/instr_fetch_pkg.sv
// rtl/instr_fetch_pkg.sv - fetch FSM states and shared constants
`include "parameters.vh"

package instr_fetch_pkg;

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [31:0] NOP_INSTR  = `NOP;
    localparam logic [6:0]  OPC_BRANCH = `OPC_BRANCH;
    localparam logic [6:0]  OPC_JAL    = `OPC_JAL;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/parameters.vh
// rtl/parameters.vh - shared instruction-fetch constants
`ifndef INSTR_FETCH_PARAMETERS_VH
`define INSTR_FETCH_PARAMETERS_VH

`define NOP              32'h0000_0013
`define OPC_BRANCH       7'b110_0011
`define OPC_JAL          7'b110_1111
`define RESET_PC_DEFAULT 32'h0000_0000

`endif

// File: rtl/static_predictor.sv
// rtl/static_predictor.sv - combinational static branch predictor
// Ports:
//   instr  : instruction word being fetched
//   pc     : address of instr
//   pred   : 1 = backward B-type or JAL, predicted taken
//   target : next fetch PC (predicted target, else pc+4)
`include "parameters.vh"

module static_predictor
    import instr_fetch_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    output logic        pred,
    output logic [31:0] target
);

    logic [31:0] b_imm;
    logic [31:0] j_imm;

    assign b_imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign j_imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        pred   = 1'b0;
        target = pc + 32'd4;
        // Sign bit of a B-type immediate is instr[31]: set means backward.
        if (instr[6:0] == OPC_BRANCH && instr[31]) begin
            pred   = 1'b1;
            target = pc + b_imm;
        end else if (instr[6:0] == OPC_JAL) begin
            pred   = 1'b1;
            target = pc + j_imm;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage with skid buffer and static prediction
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   o_imem_req, o_imem_addr    : instruction-memory request and word address
//   i_imem_ack, i_imem_rdata   : memory response, data valid with ack
//   o_instr, o_pc, o_prediction: instruction, its PC and taken prediction to decode
//   i_stall                    : decode stall, outputs held
//   i_flush, i_branch_pc       : misprediction redirect to i_branch_pc
`include "parameters.vh"

module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = `RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic        o_prediction,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic [31:0] i_branch_pc
);

    state_t      state, state_n;
    logic        req_en;
    logic [31:0] pc, pc_n;
    logic [31:0] instr_n, opc_n;
    logic        pred_n;
    logic [31:0] skid_instr, skid_instr_n;
    logic [31:0] skid_pc, skid_pc_n;

    logic [31:0] p_instr, p_pc, p_target;
    logic        p_pred;

    // req_en holds the request off for the first cycle after reset release,
    // so a late ack from before reset can never be taken as a response.
    assign o_imem_req  = req_en && (state == ST_REQ);
    assign o_imem_addr = pc;

    // In HOLD the predictor sees the buffered word instead of the bus.
    assign p_instr = (state == ST_HOLD) ? skid_instr : i_imem_rdata;
    assign p_pc    = (state == ST_HOLD) ? skid_pc : pc;

    static_predictor u_pred (
        .instr  (p_instr),
        .pc     (p_pc),
        .pred   (p_pred),
        .target (p_target)
    );

    always_comb begin
        state_n      = state;
        pc_n         = pc;
        instr_n      = o_instr;
        opc_n        = o_pc;
        pred_n       = o_prediction;
        skid_instr_n = skid_instr;
        skid_pc_n    = skid_pc;
        unique case (state)
            ST_REQ: begin
                if (i_flush) begin
                    pc_n    = word_align(i_branch_pc);
                    instr_n = NOP_INSTR;
                    pred_n  = 1'b0;
                    // Outstanding request with no ack yet: its ack must be eaten.
                    state_n = (o_imem_req && !i_imem_ack) ? ST_DRAIN : ST_REQ;
                end else if (o_imem_req && i_imem_ack) begin
                    if (i_stall) begin
                        skid_instr_n = i_imem_rdata;
                        skid_pc_n    = pc;
                        state_n      = ST_HOLD;
                    end else begin
                        instr_n = i_imem_rdata;
                        opc_n   = pc;
                        pred_n  = p_pred;
                        pc_n    = word_align(p_target);
                    end
                end else if (!i_stall) begin
                    instr_n = NOP_INSTR;
                    pred_n  = 1'b0;
                end
            end
            ST_HOLD: begin
                if (i_flush) begin
                    pc_n    = word_align(i_branch_pc);
                    instr_n = NOP_INSTR;
                    pred_n  = 1'b0;
                    state_n = ST_REQ;
                end else if (!i_stall) begin
                    instr_n = skid_instr;
                    opc_n   = skid_pc;
                    pred_n  = p_pred;
                    pc_n    = word_align(p_target);
                    state_n = ST_REQ;
                end
            end
            ST_DRAIN: begin
                if (i_flush) begin
                    pc_n = word_align(i_branch_pc);
                end
                if (i_imem_ack) begin
                    state_n = ST_REQ;
                end
            end
            default: state_n = ST_REQ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_REQ;
            req_en       <= 1'b0;
            pc           <= word_align(RESET_PC);
            o_instr      <= NOP_INSTR;
            o_pc         <= RESET_PC;
            o_prediction <= 1'b0;
            skid_instr   <= NOP_INSTR;
            skid_pc      <= 32'd0;
        end else begin
            state        <= state_n;
            req_en       <= 1'b1;
            pc           <= pc_n;
            o_instr      <= instr_n;
            o_pc         <= opc_n;
            o_prediction <= pred_n;
            skid_instr   <= skid_instr_n;
            skid_pc      <= skid_pc_n;
        end
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: PC fetched first after reset.
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port o_imem_req  output  1  instruction-memory request.
REQ-005 SHALL have port o_imem_addr  output  32  fetch address, word aligned.
REQ-006 SHALL have port i_imem_ack  input  1  response valid; i_imem_rdata valid in the same cycle.
REQ-007 SHALL have port i_imem_rdata  input  32  fetched instruction word.
REQ-008 SHALL have port o_instr  output  32  instruction to decode stage.
REQ-009 SHALL have port o_pc  output  32  PC of o_instr.
REQ-010 SHALL have port o_prediction  output  1  1 = fetch predicted o_instr as taken.
REQ-011 SHALL have port i_stall  input  1  decode-stage stall; hold outputs.
REQ-012 SHALL have port i_flush  input  1  decode-stage misprediction flush.
REQ-013 SHALL have port i_branch_pc  input  32  correct next PC, valid when i_flush=1.

Function
REQ-014 SHALL implement FSM states REQ, HOLD, DRAIN.
REQ-015 REQ: o_imem_req=1, o_imem_addr=pc; addr held stable until i_imem_ack=1.
REQ-016 REQ + ack, no stall, no flush: o_instr<=rdata, o_pc<=pc, o_prediction<=pred; pc<=target if pred else pc+4; stay REQ.
REQ-017 REQ + ack + i_stall=1, no flush: rdata, pc, pred captured into one-entry skid buffer; go HOLD; outputs unchanged.
REQ-018 HOLD: o_imem_req=0; when i_stall=0, skid entry to outputs, pc advanced per REQ-016, go REQ.
REQ-019 i_stall=1 with no ack: o_instr, o_pc, o_prediction and pc unchanged.
REQ-020 i_flush=1 has priority over i_stall and ack.
- pc<={i_branch_pc[31:2],2'b00}.
- o_instr<=`NOP, o_prediction<=0, skid entry dropped.
REQ-021 Flush while in REQ without ack in that cycle: go DRAIN; next ack discarded; then REQ at new pc.
REQ-022 Flush in same cycle as ack, or in HOLD: data discarded, go REQ.
REQ-023 DRAIN: o_imem_req=0; further flushes in DRAIN update pc only.
REQ-024 pred=1 only for:
- B-type with imm[12]=1 (backward), target pc+B-imm.
- JAL, target pc+J-imm.
- All others, including JALR, pred=0.
REQ-025 All PC arithmetic SHALL be 32-bit unsigned, wrapping modulo 2^32 (32'hFFFF_FFFC+4 = 0).
REQ-026 Latency: instruction on o_instr the cycle after its ack, given no stall.
REQ-027 SHALL emit `NOP on o_instr whenever no valid instruction is present (bubble).

Reset
REQ-028 rst_n=0 SHALL asynchronously set:
- pc=RESET_PC, state=REQ, skid empty.
- o_instr=`NOP, o_pc=RESET_PC, o_prediction=0.
REQ-029 During reset o_imem_req SHALL be 0; first request issued the cycle after rst_n rises.
REQ-030 Reset mid-transaction SHALL abandon the outstanding request; a late ack after reset is treated as response to the new RESET_PC request only if o_imem_req was re-asserted.

Structure
REQ-031 `NOP, opcode codes (B-type, JAL) and RESET_PC default SHALL live in rtl/parameters.vh.
REQ-032 Prediction decode SHALL be sub-module static_predictor (instr, pc -> pred, target), combinational.

Verification
REQ-033 Reset release, ack every second cycle, rdata=32'h00000013 -> addr sequence 0,4,8; o_pc follows one cycle after each ack.
REQ-034 Ack with i_stall=1 for 3 cycles -> o_imem_req=0 during HOLD; buffered word appears when stall drops; no instruction lost or duplicated.
REQ-035 pc=0x100, rdata=32'hFE000EE3 (beq, imm=-4) -> o_prediction=1, next addr 0x0FC.
REQ-036 i_flush=1, i_branch_pc=0x206 while request outstanding -> stale ack discarded, next addr 0x204, o_instr=`NOP.
REQ-037 pc=32'hFFFF_FFFC, non-branch ack -> next addr 0x0000_0000.
REQ-038 Flush and stall in same cycle -> flush wins; rst_n pulsed mid-WAIT -> outputs at reset values, fetch restarts at RESET_PC.
